// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiply and
// restoring shift-subtract divide on operand magnitudes, followed by a
// one-cycle sign-correction step. Divide by zero finishes immediately.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // |b|: multiplicand or divisor
    logic [WIDTH-1:0]   work_hi_q, work_hi_d; // partial product high / remainder
    logic [WIDTH-1:0]   work_lo_q, work_lo_d; // multiplier / dividend -> quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    logic               in_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;

    assign in_signed = ~op[0];
    assign mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;

    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign prod      = {work_hi_q, work_lo_q};

    // Next-state, datapath iteration and result write-back
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        opnd_d    = opnd_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div0_d    = div0_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = in_signed & a[WIDTH-1];
                    sign_b_d = in_signed & b[WIDTH-1];
                    cnt_d    = '0;
                    div0_d   = 1'b0;
                    if (op[1] && (b == '0)) begin
                        // No iterations needed: flag and finish on the accepting edge
                        div0_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        opnd_d    = mag_b;
                        work_hi_d = '0;
                        work_lo_d = mag_a;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    work_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    work_hi_d = mul_sum[WIDTH:1];
                    work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q[1]) begin
                    // Quotient sign follows the operand signs, remainder follows the dividend
                    lo_d = (sign_a_q ^ sign_b_q) ? -work_lo_q : work_lo_q;
                    hi_d = sign_a_q ? -work_hi_q : work_hi_q;
                end else begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -prod : prod;
                end
                done_d  = 1'b1;
                state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            opnd_q    <= opnd_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == FIX);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed vectors,
// randomized operations against an arithmetic reference, and reset abort.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi, m_lo;

    logic [1:0]  dv_op  [7];
    logic [31:0] dv_a   [7];
    logic [31:0] dv_b   [7];
    logic [31:0] dv_hi  [7];
    logic [31:0] dv_lo  [7];
    logic        dv_d0  [7];
    int          dv_lat [7];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo),
        .div0 (div0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2ms", $time);
        $fatal(1, "watchdog");
    end

    // Reference: returns {div0, hi, lo}; divide by zero keeps previous hi/lo.
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, y,
                                           input logic [31:0] ph, pl);
        longint          sp;
        longint unsigned up;
        int              sx, sy, q, r;
        case (o)
            2'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return {1'b0, 64'(sp)};
            end
            2'd1: begin
                up = 64'(x) * 64'(y);
                return {1'b0, up};
            end
            2'd2: begin
                if (y == 32'd0) return {1'b1, ph, pl};
                sx = x;
                sy = y;
                if (sx == 32'sh8000_0000 && sy == -1) begin
                    q = sx;
                    r = 0;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                end
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (y == 32'd0) return {1'b1, ph, pl};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done; no checking here.
    // While busy, start/op/a/b are driven with junk that must be ignored.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, y,
                         output int lat, output int busy_n,
                         output logic busy_first, output logic div0_first);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        lat        = 0;
        busy_n     = 0;
        busy_first = 1'b0;
        div0_first = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (i == 0) begin
                busy_first = busy;
                div0_first = div0;
            end
            start = 1'b0;
            if (done) break;
            if (busy) begin
                busy_n++;
                start = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom_range(0, 1) == 1 ? 32'd0 : $urandom;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd9;
        b     = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0: got %b, required 0", div0); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h, required 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h, required 0", lo); end
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got busy=%b done=%b, required 0 0", busy, done);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_directed();
        int   lat, busy_n;
        logic bf, d0f;
        dv_op  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2};
        dv_a   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd9, 32'd3, 32'h8000_0000};
        dv_b   = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'd4, 32'hFFFF_FFFF};
        dv_hi  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd0};
        dv_lo  = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'd3, 32'd3, 32'd12, 32'h8000_0000};
        dv_d0  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dv_lat = '{34, 34, 34, 34, 1, 34, 34};
        for (int i = 0; i < 7; i++) begin
            do_op(dv_op[i], dv_a[i], dv_b[i], lat, busy_n, bf, d0f);
            n_checks++; if (lat !== dv_lat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d, required %0d", i, lat, dv_lat[i]); end
            n_checks++; if (hi !== dv_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h, required %h", i, hi, dv_hi[i]); end
            n_checks++; if (lo !== dv_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h, required %h", i, lo, dv_lo[i]); end
            n_checks++; if (div0 !== dv_d0[i]) begin n_fail++; $display("FAIL dir%0d_div0: got %b, required %b", i, div0, dv_d0[i]); end
            if (i > 0) begin
                // every vector after the first is started in the previous FIN cycle
                n_checks++; if (bf !== (dv_lat[i] != 1)) begin
                    n_fail++; $display("FAIL dir%0d_b2b_busy: got %b, required %b", i, bf, (dv_lat[i] != 1));
                end
            end
            if (i == 5) begin
                n_checks++; if (d0f !== 1'b0) begin n_fail++; $display("FAIL dir5_div0_clear: got %b, required 0", d0f); end
            end
        end
        m_hi = dv_hi[6];
        m_lo = dv_lo[6];
        @(posedge clock);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_done_single: got %b, required 0", done); end
    endtask

    task automatic test_random();
        int          lat, busy_n, exp_lat;
        logic        bf, d0f;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [64:0] e;
        for (int n = 0; n < 150; n++) begin
            o = 2'($urandom_range(0, 3));
            x = pick32();
            y = pick32();
            e = ref_op(o, x, y, m_hi, m_lo);
            exp_lat = (o[1] && y == 32'd0) ? 1 : 34;
            do_op(o, x, y, lat, busy_n, bf, d0f);
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d a=%h b=%h: got %0d, required %0d", n, o, x, y, lat, exp_lat); end
            n_checks++; if (busy_n !== exp_lat - 1) begin n_fail++; $display("FAIL rnd%0d_busy_cycles: got %0d, required %0d", n, busy_n, exp_lat - 1); end
            n_checks++; if (hi !== e[63:32]) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h, required %h", n, o, x, y, hi, e[63:32]); end
            n_checks++; if (lo !== e[31:0]) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h, required %h", n, o, x, y, lo, e[31:0]); end
            n_checks++; if (div0 !== e[64]) begin n_fail++; $display("FAIL rnd%0d_div0: got %b, required %b", n, div0, e[64]); end
            m_hi = e[63:32];
            m_lo = e[31:0];
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock);
                    #1;
                    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                        n_fail++; $display("FAIL rnd%0d_idle: got done=%b busy=%b, required 0 0", n, done, busy);
                    end
                    n_checks++; if (hi !== m_hi || lo !== m_lo || div0 !== e[64]) begin
                        n_fail++; $display("FAIL rnd%0d_hold: got %h/%h/%b, required %h/%h/%b", n, hi, lo, div0, m_hi, m_lo, e[64]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        @(negedge clock);
        start = 1'b1;
        op    = 2'd0;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (c == 5) begin
                start = 1'b1;
                op    = 2'd3;
                b     = 32'd0;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (c == 5) begin
                n_checks++; if (busy !== 1'b1 || done !== 1'b0 || div0 !== 1'b0) begin
                    n_fail++; $display("FAIL abort_start_ignored: got busy=%b done=%b div0=%b, required 1 0 0", busy, done, div0);
                end
            end
        end
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo: got %h/%h, required 0/0", hi, lo); end
        n_checks++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL abort_div0: got %b, required 0", div0); end
        saw_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity=%b, required 0", saw_done); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
